// File: rtl/obstacle_pkg.sv
// Shared encodings for the obstacle scheduler: FSM states, mux select constants, LFSR seed/taps.
package obstacle_pkg;

  localparam int OBSTACLE_SEL_W = 4;
  localparam logic [OBSTACLE_SEL_W-1:0] SEL_NONE = 4'hF;

  // x^8+x^6+x^5+x^4+1, shifting left: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_ATTACK = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obstacle_index_gen.sv
// Picks the obstacle index for the next attack: sequential wrap, or LFSR-based when
// OBSTACLE_SCHED_RANDOM_EN is defined (never repeats the previous index if more than one obstacle).
import obstacle_pkg::*;

module obstacle_index_gen #(
  parameter int NUM_OBSTACLES = 2
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      i_restart,
  input  logic                      i_load,
  output logic [OBSTACLE_SEL_W-1:0] o_next_idx
);

  logic [OBSTACLE_SEL_W-1:0] r_last_idx;
  logic                      r_have_prev;
  logic [OBSTACLE_SEL_W-1:0] w_seq_idx;

  always_ff @(posedge pclk) begin
    if (rst || i_restart) begin
      r_last_idx  <= '0;
      r_have_prev <= 1'b0;
    end else if (i_load) begin
      r_last_idx  <= o_next_idx;
      r_have_prev <= 1'b1;
    end
  end

  assign w_seq_idx = (r_last_idx == OBSTACLE_SEL_W'(NUM_OBSTACLES - 1)) ? '0 : r_last_idx + 1'b1;

`ifdef OBSTACLE_SCHED_RANDOM_EN
  logic [7:0]                r_lfsr;
  logic [OBSTACLE_SEL_W-1:0] w_cand;

  always_ff @(posedge pclk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr_step(r_lfsr);
  end

  assign w_cand     = OBSTACLE_SEL_W'(32'(r_lfsr) % NUM_OBSTACLES);
  assign o_next_idx = (r_have_prev && (NUM_OBSTACLES > 1) && (w_cand == r_last_idx)) ? w_seq_idx : w_cand;
`else
  assign o_next_idx = r_have_prev ? w_seq_idx : '0;
`endif

endmodule

// File: rtl/obstacle_scheduler.sv
// Frame-paced obstacle attack sequencer (IDLE/GAP/ATTACK/HALT) driving a 16:1 obstacle mux.
// Define OBSTACLE_SCHED_RANDOM_EN for LFSR-driven obstacle order instead of sequential.
//   state  | meaning
//   IDLE   | not playing, outputs at reset values
//   GAP    | blank frames between attacks, sel = SEL_NONE
//   ATTACK | one obstacle selected for ATTACK_FRAMES frames
//   HALT   | player dead, sel frozen until play_selected drops
import obstacle_pkg::*;

module obstacle_scheduler #(
  parameter int NUM_OBSTACLES = 2,
  parameter int ATTACK_FRAMES = 600,
  parameter int GAP_FRAMES    = 60
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      vsync_in,
  input  logic                      play_selected,
  input  logic                      game_over,
  output logic [OBSTACLE_SEL_W-1:0] obstacle_sel,
  output logic                      obstacle_start,
  output logic                      attack_active,
  output logic [7:0]                round_cnt,
  output logic [1:0]                state_out
);

  state_t                    r_state;
  logic                      r_vsync_d;
  logic [15:0]               r_frame_cnt;
  logic [OBSTACLE_SEL_W-1:0] r_sel;
  logic                      r_start;
  logic                      r_active;
  logic [7:0]                r_round;

  state_t                    w_next_state;
  logic                      w_frame_tick;
  logic                      w_gap_done;
  logic                      w_atk_done;
  logic                      w_enter_attack;
  logic                      w_attack_done;
  logic                      w_restart;
  logic [OBSTACLE_SEL_W-1:0] w_next_idx;
  logic [OBSTACLE_SEL_W-1:0] w_sel_next;
  logic [7:0]                w_round_next;
  logic [15:0]               w_frame_cnt_next;

  assign w_frame_tick = vsync_in & ~r_vsync_d;
  assign w_gap_done   = w_frame_tick && (r_frame_cnt == 16'(GAP_FRAMES - 1));
  assign w_atk_done   = w_frame_tick && (r_frame_cnt == 16'(ATTACK_FRAMES - 1));

  obstacle_index_gen #(
    .NUM_OBSTACLES (NUM_OBSTACLES)
  ) u_index_gen (
    .pclk       (pclk),
    .rst        (rst),
    .i_restart  (w_restart),
    .i_load     (w_enter_attack),
    .o_next_idx (w_next_idx)
  );

  always_comb begin
    w_next_state = r_state;
    // game_over beats timer expiry; play_selected low beats timer expiry
    case (r_state)
      ST_IDLE:   if (play_selected) w_next_state = ST_GAP;
      ST_GAP: begin
        if (game_over)           w_next_state = ST_HALT;
        else if (!play_selected) w_next_state = ST_IDLE;
        else if (w_gap_done)     w_next_state = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (game_over)           w_next_state = ST_HALT;
        else if (!play_selected) w_next_state = ST_IDLE;
        else if (w_atk_done)     w_next_state = ST_GAP;
      end
      ST_HALT:   if (!game_over && !play_selected) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase

    w_enter_attack = (r_state == ST_GAP)    && (w_next_state == ST_ATTACK);
    w_attack_done  = (r_state == ST_ATTACK) && (w_next_state == ST_GAP);
    w_restart      = (r_state == ST_IDLE)   && (w_next_state == ST_GAP);

    case (w_next_state)
      ST_ATTACK: w_sel_next = w_enter_attack ? w_next_idx : r_sel;
      ST_HALT:   w_sel_next = r_sel;
      default:   w_sel_next = SEL_NONE;
    endcase

    if ((w_next_state == ST_IDLE) || w_restart) w_round_next = 8'd0;
    else if (w_attack_done)                     w_round_next = (r_round == 8'hFF) ? r_round : r_round + 8'd1;
    else                                        w_round_next = r_round;

    if (w_next_state != r_state)
      w_frame_cnt_next = 16'd0;
    else if (w_frame_tick && ((r_state == ST_GAP) || (r_state == ST_ATTACK)))
      w_frame_cnt_next = r_frame_cnt + 16'd1;
    else
      w_frame_cnt_next = r_frame_cnt;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vsync_d   <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_sel       <= SEL_NONE;
      r_start     <= 1'b0;
      r_active    <= 1'b0;
      r_round     <= 8'd0;
    end else begin
      r_state     <= w_next_state;
      r_vsync_d   <= vsync_in;
      r_frame_cnt <= w_frame_cnt_next;
      r_sel       <= w_sel_next;
      r_start     <= w_enter_attack;
      r_active    <= (w_next_state == ST_ATTACK);
      r_round     <= w_round_next;
    end
  end

  assign obstacle_sel   = r_sel;
  assign obstacle_start = r_start;
  assign attack_active  = r_active;
  assign round_cnt      = r_round;
  assign state_out      = r_state;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler (ATTACK_FRAMES=4, GAP_FRAMES=2, 100-pclk frames);
// a second instance with NUM_OBSTACLES=1 shares the stimulus.
module tb_obstacle_scheduler;

  localparam int N  = 2;
  localparam int AF = 4;
  localparam int GF = 2;

  logic       pclk = 1'b0;
  logic       rst, vsync_in, play_selected, game_over;
  logic [3:0] obstacle_sel, obstacle_sel_1;
  logic       obstacle_start, obstacle_start_1;
  logic       attack_active, attack_active_1;
  logic [7:0] round_cnt, round_cnt_1;
  logic [1:0] state_out, state_out_1;

  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int exp_q[$];
  int m_last;
  bit m_have_prev;
  int m_round;

  obstacle_scheduler #(.NUM_OBSTACLES(N), .ATTACK_FRAMES(AF), .GAP_FRAMES(GF)) u_dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .play_selected(play_selected), .game_over(game_over),
    .obstacle_sel(obstacle_sel), .obstacle_start(obstacle_start), .attack_active(attack_active),
    .round_cnt(round_cnt), .state_out(state_out));

  obstacle_scheduler #(.NUM_OBSTACLES(1), .ATTACK_FRAMES(AF), .GAP_FRAMES(GF)) u_dut1 (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .play_selected(play_selected), .game_over(game_over),
    .obstacle_sel(obstacle_sel_1), .obstacle_start(obstacle_start_1), .attack_active(attack_active_1),
    .round_cnt(round_cnt_1), .state_out(state_out_1));

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    #1;
    if (obstacle_start) start_cnt++;
  end

`ifdef OBSTACLE_SCHED_RANDOM_EN
  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] m_used = 8'hA5;
  int         g_prev_sel = -1;
  always @(posedge pclk) begin
    m_used <= m_lfsr;
    m_lfsr <= rst ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  // Reference choice of the next attack index; commits it as the new "previous".
  function automatic int model_next();
    int c;
`ifdef OBSTACLE_SCHED_RANDOM_EN
    c = int'(m_used) % N;
    if (m_have_prev && N > 1 && c == m_last) c = (m_last + 1) % N;
`else
    c = m_have_prev ? (m_last + 1) % N : 0;
`endif
    m_last      = c;
    m_have_prev = 1'b1;
    return c;
  endfunction

  task automatic model_restart();
    m_have_prev = 1'b0;
    m_round     = 0;
`ifdef OBSTACLE_SCHED_RANDOM_EN
    g_prev_sel  = -1;
`endif
  endtask

  task automatic tick_edge();
    vsync_in = 1'b1;
    @(negedge pclk);
  endtask

  task automatic tick_tail();
    repeat (9) @(negedge pclk);
    vsync_in = 1'b0;
    repeat (90) @(negedge pclk);
  endtask

  task automatic full_frame();
    tick_edge();
    tick_tail();
  endtask

  // Starts in GAP with a cleared frame counter; ends in GAP after one complete attack.
  task automatic run_round(input string tag, input bit long_hold);
    int s0, e;
    if (long_hold) begin
      vsync_in = 1'b1;
      repeat (300) @(negedge pclk);
      vsync_in = 1'b0;
      repeat (50) @(negedge pclk);
    end else begin
      full_frame();
    end
    n_checks++;
    if (state_out !== 2'd1) begin n_fail++; $display("FAIL %s gap_after_1_tick state=%0d exp=1", tag, state_out); end
    s0 = start_cnt;
    tick_edge();
    exp_q.push_back(model_next());
    n_checks++;
    if (state_out !== 2'd2) begin n_fail++; $display("FAIL %s attack_entry state=%0d exp=2", tag, state_out); end
    n_checks++;
    if (obstacle_start !== 1'b1 || attack_active !== 1'b1) begin
      n_fail++; $display("FAIL %s entry_flags start=%b active=%b exp=1,1", tag, obstacle_start, attack_active);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (obstacle_sel !== 4'(e)) begin n_fail++; $display("FAIL %s sel got=%0d exp=%0d", tag, obstacle_sel, e); end
    n_checks++;
    if (obstacle_sel_1 !== 4'd0 || {state_out_1, obstacle_start_1, attack_active_1} !== 4'b1011) begin
      n_fail++; $display("FAIL %s single_obstacle sel=%0d state=%0d start=%b active=%b exp=0,2,1,1",
                         tag, obstacle_sel_1, state_out_1, obstacle_start_1, attack_active_1);
    end
`ifdef OBSTACLE_SCHED_RANDOM_EN
    n_checks++;
    if (obstacle_sel > 4'd1 || int'(obstacle_sel) == g_prev_sel) begin
      n_fail++; $display("FAIL %s random_sel got=%0d prev=%0d exp_in_0_1_and_new", tag, obstacle_sel, g_prev_sel);
    end
    g_prev_sel = int'(obstacle_sel);
`endif
    @(negedge pclk);
    n_checks++;
    if (obstacle_start !== 1'b0) begin n_fail++; $display("FAIL %s start_width start=%b exp=0", tag, obstacle_start); end
    repeat (8) @(negedge pclk);
    vsync_in = 1'b0;
    repeat (90) @(negedge pclk);
    n_checks++;
    if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL %s start_pulses got=%0d exp=1", tag, start_cnt - s0); end
    repeat (AF - 1) full_frame();
    n_checks++;
    if (state_out !== 2'd2 || obstacle_sel !== 4'(e)) begin
      n_fail++; $display("FAIL %s attack_hold state=%0d sel=%0d exp=2,%0d", tag, state_out, obstacle_sel, e);
    end
    tick_edge();
    m_round = (m_round == 255) ? 255 : m_round + 1;
    n_checks++;
    if (state_out !== 2'd1 || obstacle_sel !== 4'hF || attack_active !== 1'b0) begin
      n_fail++; $display("FAIL %s attack_exit state=%0d sel=%h active=%b exp=1,f,0", tag, state_out, obstacle_sel, attack_active);
    end
    n_checks++;
    if (round_cnt !== 8'(m_round) || round_cnt_1 !== 8'(m_round)) begin
      n_fail++; $display("FAIL %s round_cnt got=%0d/%0d exp=%0d", tag, round_cnt, round_cnt_1, m_round);
    end
    tick_tail();
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync_in = 1'b0; play_selected = 1'b0; game_over = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++;
    if (obstacle_sel !== 4'hF) begin n_fail++; $display("FAIL reset_sel got=%h exp=f", obstacle_sel); end
    n_checks++;
    if (obstacle_start !== 1'b0 || attack_active !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags start=%b active=%b exp=0,0", obstacle_start, attack_active);
    end
    n_checks++;
    if (round_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_round got=%0d exp=0", round_cnt); end
    n_checks++;
    if (state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    rst = 1'b0;
    repeat (2) @(negedge pclk);
    n_checks++;
    if (state_out !== 2'd0) begin n_fail++; $display("FAIL idle_without_play state=%0d exp=0", state_out); end
    model_restart();
  endtask

  task automatic test_first_attack();
    play_selected = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (state_out !== 2'd1 || obstacle_sel !== 4'hF || round_cnt !== 8'd0) begin
      n_fail++; $display("FAIL play_to_gap state=%0d sel=%h round=%0d exp=1,f,0", state_out, obstacle_sel, round_cnt);
    end
    run_round("first", 1'b0);
  endtask

  task automatic test_rounds();
    run_round("round2", 1'b0);
    run_round("round3", 1'b0);
  endtask

  task automatic test_gameover_expiry();
    int s0, e;
    full_frame();
    tick_edge();
    e = model_next();
    n_checks++;
    if (state_out !== 2'd2 || obstacle_sel !== 4'(e)) begin
      n_fail++; $display("FAIL go_entry state=%0d sel=%0d exp=2,%0d", state_out, obstacle_sel, e);
    end
    tick_tail();
    repeat (AF - 1) full_frame();
    s0 = start_cnt;
    game_over = 1'b1;
    tick_edge();
    n_checks++;
    if (state_out !== 2'd3 || attack_active !== 1'b0) begin
      n_fail++; $display("FAIL go_halt state=%0d active=%b exp=3,0", state_out, attack_active);
    end
    n_checks++;
    if (round_cnt !== 8'(m_round) || obstacle_sel !== 4'(e)) begin
      n_fail++; $display("FAIL go_hold round=%0d sel=%0d exp=%0d,%0d", round_cnt, obstacle_sel, m_round, e);
    end
    game_over = 1'b0;
    repeat (5) @(negedge pclk);
    n_checks++;
    if (state_out !== 2'd3 || obstacle_sel !== 4'(e) || start_cnt != s0) begin
      n_fail++; $display("FAIL halt_persist state=%0d sel=%0d starts=%0d exp=3,%0d,0", state_out, obstacle_sel, e, start_cnt - s0);
    end
    play_selected = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (state_out !== 2'd0 || obstacle_sel !== 4'hF || round_cnt !== 8'd0) begin
      n_fail++; $display("FAIL halt_to_idle state=%0d sel=%h round=%0d exp=0,f,0", state_out, obstacle_sel, round_cnt);
    end
    model_restart();
    tick_tail();
  endtask

  task automatic test_reset_mid_attack();
    int s0, e;
    play_selected = 1'b1;
    @(negedge pclk);
    full_frame();
    tick_edge();
    e = model_next();
    n_checks++;
    if (state_out !== 2'd2 || obstacle_sel !== 4'(e)) begin
      n_fail++; $display("FAIL rst_entry state=%0d sel=%0d exp=2,%0d", state_out, obstacle_sel, e);
    end
    tick_tail();
    full_frame();
    s0 = start_cnt;
    rst = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (state_out !== 2'd0 || obstacle_sel !== 4'hF || attack_active !== 1'b0 || round_cnt !== 8'd0 || obstacle_start !== 1'b0) begin
      n_fail++; $display("FAIL mid_attack_reset state=%0d sel=%h active=%b round=%0d start=%b exp=0,f,0,0,0",
                         state_out, obstacle_sel, attack_active, round_cnt, obstacle_start);
    end
    @(negedge pclk);
    rst = 1'b0;
    model_restart();
    @(negedge pclk);
    n_checks++;
    if (state_out !== 2'd1 || round_cnt !== 8'd0 || start_cnt != s0) begin
      n_fail++; $display("FAIL restart_gap state=%0d round=%0d starts=%0d exp=1,0,0", state_out, round_cnt, start_cnt - s0);
    end
  endtask

  task automatic test_long_vsync();
    run_round("long_vsync", 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) run_round($sformatf("b2b%0d", i), 1'b0);
  endtask

  initial begin
    rst = 1'b1; vsync_in = 1'b0; play_selected = 1'b0; game_over = 1'b0;
    @(negedge pclk);
    test_reset();
    test_first_attack();
    test_rounds();
    test_gameover_expiry();
    test_reset_mid_attack();
    test_long_vsync();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
